// File: rtl/qed_wb_checker_if.sv
// Retired register-writeback bus observed by the QED writeback checker.
// The core side drives it (master) and the checker samples it (slave).
interface qed_wb_checker_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (output wb_valid, output wb_rd, output wb_data);
    modport slave  (input  wb_valid, input  wb_rd, input  wb_data);
endinterface

// File: rtl/qed_wb_checker.sv
// QED writeback checker: queues original writebacks (x1-x15) in order and compares
// each duplicate writeback (x17-x31) against the oldest pending original.
module qed_wb_checker #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    qed_wb_checker_if.slave          wb,
    output logic                     qed_ready,
    output logic                     qed_error,
    output logic [1:0]               err_code,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PEND_W = AW + 1;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_UNDER    = 2'd2;
    localparam logic [1:0] ERR_OVER     = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]  mem_rd   [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic is_orig;
    logic is_dup;
    logic is_illegal;
    logic fifo_full;
    logic fifo_empty;
    logic head_match;

    logic       push;
    logic       pop;
    logic       flush;
    logic       cnt_inc;
    logic       err_set;
    logic [1:0] err_cause;

    // Register-number classification; rd=0 falls into none of the three groups.
    always_comb begin
        is_orig    = (wb.wb_rd[4] == 1'b0) && (wb.wb_rd[3:0] != 4'd0);
        is_dup     = (wb.wb_rd[4] == 1'b1) && (wb.wb_rd[3:0] != 4'd0);
        is_illegal = (wb.wb_rd == 5'd16);
    end

    always_comb begin
        fifo_full  = (pending == PEND_W'(DEPTH));
        fifo_empty = (pending == '0);
        head_match = (mem_rd[rd_ptr] == wb.wb_rd[3:0]) && (mem_data[rd_ptr] == wb.wb_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        err_cause  = ERR_NONE;
        case (state)
            IDLE: begin
                if (ena) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (!ena) begin
                    next_state = IDLE;
                    flush      = 1'b1;
                end else if (wb.wb_valid) begin
                    if (is_orig) begin
                        if (fifo_full) begin
                            err_set   = 1'b1;
                            err_cause = ERR_OVER;
                        end else begin
                            push = 1'b1;
                        end
                    end else if (is_dup) begin
                        if (fifo_empty) begin
                            err_set   = 1'b1;
                            err_cause = ERR_UNDER;
                        end else begin
                            pop = 1'b1;
                            if (head_match) begin
                                cnt_inc = 1'b1;
                            end else begin
                                err_set   = 1'b1;
                                err_cause = ERR_MISMATCH;
                            end
                        end
                    end else if (is_illegal) begin
                        err_set   = 1'b1;
                        err_cause = ERR_OVER;
                    end
                    if (err_set) begin
                        next_state = ERROR;
                    end
                end
            end
            ERROR: begin
                next_state = ERROR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Storage carries no reset; only entries below 'pending' are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= wb.wb_rd[3:0];
            mem_data[wr_ptr] <= wb.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                pending <= pending + PEND_W'(1);
            end else if (pop && !push) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

    // Saturating pair counter: holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (cnt_inc && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qed_error <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (err_set && !qed_error) begin
            qed_error <= 1'b1;
            err_code  <= err_cause;
        end
    end

    always_comb begin
        qed_ready = (state == CHECK) && fifo_empty && (match_cnt != '0);
    end

endmodule
